ldst_arbiter: RTL and testbench

Shares one downstream `ldst` memory port between `N_REQ` upstream load/store requesters, e.g. the EXU load/store handlers and a debug/DMA master. Uses round-robin arbitration with a sticky grant, so the selected request is stable while the downstream port stalls. Tracks up to `MAX_OUT` outstanding transactions in an in-order ID FIFO and routes each downstream response back to the requester that issued it. Sits between the requesters' `ldst` master ports and the memory-side `ldst` slave.

---
 rtl/ldst_arbiter.sv | 150 +++++++++++++++
 tb/tb_ldst_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldst_arbiter.sv
// Round-robin arbiter sharing one downstream ldst port among N_REQ requesters,
// with sticky grant under stall and an in-order ID FIFO for response routing.
module ldst_arbiter #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned MAX_OUT = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_REQ-1:0]               up_req_vld,
  output logic [N_REQ-1:0]               up_req_rdy,
  input  logic [N_REQ*AW-1:0]            up_req_addr,
  input  logic [N_REQ-1:0]               up_req_st,
  input  logic [N_REQ*DW-1:0]            up_req_data,
  output logic [N_REQ-1:0]               up_rsp_vld,
  input  logic [N_REQ-1:0]               up_rsp_rdy,
  output logic [DW-1:0]                  up_rsp_data,
  output logic                           dn_req_vld,
  input  logic                           dn_req_rdy,
  output logic [AW-1:0]                  dn_req_addr,
  output logic                           dn_req_st,
  output logic [DW-1:0]                  dn_req_data,
  input  logic                           dn_rsp_vld,
  output logic                           dn_rsp_rdy,
  input  logic [DW-1:0]                  dn_rsp_data,
  output logic [$clog2(MAX_OUT+1)-1:0]   out_cnt,
  output logic                           err_orphan
);

  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CW  = $clog2(MAX_OUT + 1);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] lock_id;
  logic           lock_vld;
  logic [IDW-1:0] cand_id;
  logic           cand_vld;
  logic [IDW-1:0] winner;
  logic           sel_vld;
  logic           can_issue;
  logic           dn_req_hs;
  logic           rsp_pop;
  logic           fifo_empty;
  logic [IDW-1:0] head;
  logic [IDW-1:0] id_mem [MAX_OUT];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == MAX_OUT - 1) ? '0 : p + 1'b1;
  endfunction

  // First valid requester at or after rr_ptr, with wrap-around.
  always_comb begin
    cand_vld = 1'b0;
    cand_id  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!cand_vld && up_req_vld[i] && ((32'(rr_ptr) + k) % N_REQ) == i) begin
          cand_vld = 1'b1;
          cand_id  = IDW'(i);
        end
      end
    end
  end

  // A locked grant relies on the requester holding vld until accepted.
  assign winner     = lock_vld ? lock_id : cand_id;
  assign sel_vld    = lock_vld | cand_vld;
  assign fifo_empty = (out_cnt == '0);
  assign head       = id_mem[rd_ptr];
  assign rsp_pop    = !fifo_empty & dn_rsp_vld & dn_rsp_rdy;
  assign can_issue  = (out_cnt < CW'(MAX_OUT)) | rsp_pop;
  assign dn_req_vld = sel_vld & can_issue;
  assign dn_req_hs  = dn_req_vld & dn_req_rdy;

  // Downstream packet mux and per-requester ready.
  always_comb begin
    up_req_rdy  = '0;
    dn_req_addr = '0;
    dn_req_st   = 1'b0;
    dn_req_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (winner == IDW'(i)) begin
        dn_req_addr   = up_req_addr[i*AW +: AW];
        dn_req_st     = up_req_st[i];
        dn_req_data   = up_req_data[i*DW +: DW];
        up_req_rdy[i] = dn_req_rdy & can_issue;
      end
    end
  end

  // Route responses to the FIFO head; drain responses with no owner.
  always_comb begin
    up_rsp_vld = '0;
    dn_rsp_rdy = 1'b1;
    if (!fifo_empty) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (head == IDW'(i)) begin
          up_rsp_vld[i] = dn_rsp_vld;
          dn_rsp_rdy    = up_rsp_rdy[i];
        end
      end
    end
  end

  assign up_rsp_data = dn_rsp_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      lock_vld   <= 1'b0;
      lock_id    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      out_cnt    <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (dn_req_hs) begin
        rr_ptr   <= (32'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
        lock_vld <= 1'b0;
        wr_ptr   <= ptr_inc(wr_ptr);
      end else if (dn_req_vld) begin
        lock_vld <= 1'b1;
        lock_id  <= winner;
      end
      if (rsp_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({dn_req_hs, rsp_pop})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
      if (fifo_empty && dn_rsp_vld) begin
        err_orphan <= 1'b1;
      end
    end
  end

  // ID storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (dn_req_hs) begin
      id_mem[wr_ptr] <= winner;
    end
  end

endmodule

// File: tb/tb_ldst_arbiter.sv
// Directed bench for ldst_arbiter: expected grants and outstanding IDs are
// queued as stimulus is driven and checked as the DUT hands them off.
module tb_ldst_arbiter;

  localparam int unsigned N_REQ   = 2;
  localparam int unsigned MAX_OUT = 2;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic        st;
    logic [31:0] data;
  } req_t;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [N_REQ-1:0]              up_req_vld;
  logic [N_REQ-1:0]              up_req_rdy;
  logic [N_REQ*AW-1:0]           up_req_addr;
  logic [N_REQ-1:0]              up_req_st;
  logic [N_REQ*DW-1:0]           up_req_data;
  logic [N_REQ-1:0]              up_rsp_vld;
  logic [N_REQ-1:0]              up_rsp_rdy;
  logic [DW-1:0]                 up_rsp_data;
  logic                          dn_req_vld;
  logic                          dn_req_rdy;
  logic [AW-1:0]                 dn_req_addr;
  logic                          dn_req_st;
  logic [DW-1:0]                 dn_req_data;
  logic                          dn_rsp_vld;
  logic                          dn_rsp_rdy;
  logic [DW-1:0]                 dn_rsp_data;
  logic [$clog2(MAX_OUT+1)-1:0]  out_cnt;
  logic                          err_orphan;

  int   n_cmp  = 0;
  int   n_mism = 0;
  req_t req_q[$];
  int   id_q[$];
  logic orphan_exp = 1'b0;

  always #5 clk = ~clk;

  ldst_arbiter #(.N_REQ(N_REQ), .MAX_OUT(MAX_OUT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_req_vld(up_req_vld), .up_req_rdy(up_req_rdy), .up_req_addr(up_req_addr),
    .up_req_st(up_req_st), .up_req_data(up_req_data),
    .up_rsp_vld(up_rsp_vld), .up_rsp_rdy(up_rsp_rdy), .up_rsp_data(up_rsp_data),
    .dn_req_vld(dn_req_vld), .dn_req_rdy(dn_req_rdy), .dn_req_addr(dn_req_addr),
    .dn_req_st(dn_req_st), .dn_req_data(dn_req_data),
    .dn_rsp_vld(dn_rsp_vld), .dn_rsp_rdy(dn_rsp_rdy), .dn_rsp_data(dn_rsp_data),
    .out_cnt(out_cnt), .err_orphan(err_orphan)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mism++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [31:0] addr, input logic st,
                         input logic [31:0] data);
    up_req_addr[id*AW +: AW] = addr;
    up_req_st[id]            = st;
    up_req_data[id*DW +: DW] = data;
  endtask

  task automatic expect_req(input int id, input logic [31:0] addr, input logic st,
                            input logic [31:0] data);
    req_t e;
    e.id = id; e.addr = addr; e.st = st; e.data = data;
    req_q.push_back(e);
  endtask

  // One clock: check everything observable against the queued model, then commit.
  task automatic tick();
    req_t e;
    int   h;
    bit   pop;
    bit   orphan_now;
    pop        = 1'b0;
    orphan_now = 1'b0;
    @(negedge clk);
    check("out_cnt", 64'(out_cnt), 64'(id_q.size()));
    check("err_orphan", 64'(err_orphan), 64'(orphan_exp));
    if (id_q.size() == 0) begin
      check("up_rsp_vld_empty", 64'(up_rsp_vld), 64'd0);
      if (dn_rsp_vld) begin
        check("drain_rdy", 64'(dn_rsp_rdy), 64'd1);
        orphan_now = 1'b1;
      end
    end else begin
      h = id_q[0];
      check("dn_rsp_rdy", 64'(dn_rsp_rdy), 64'(up_rsp_rdy[h]));
      check("up_rsp_vld", 64'(up_rsp_vld), dn_rsp_vld ? 64'(1 << h) : 64'd0);
      if (dn_rsp_vld && up_rsp_rdy[h]) begin
        check("up_rsp_data", 64'(up_rsp_data), 64'(dn_rsp_data));
        pop = 1'b1;
      end
    end
    if (dn_req_vld && dn_req_rdy) begin
      if (req_q.size() == 0) begin
        check("unexpected_grant", 64'(dn_req_addr), 64'hdead_0000);
      end else begin
        e = req_q.pop_front();
        check("dn_req_addr", 64'(dn_req_addr), 64'(e.addr));
        check("dn_req_st", 64'(dn_req_st), 64'(e.st));
        check("dn_req_data", 64'(dn_req_data), 64'(e.data));
        check("up_req_rdy", 64'(up_req_rdy), 64'(1 << e.id));
        if (pop) void'(id_q.pop_front());
        pop = 1'b0;
        id_q.push_back(e.id);
      end
    end
    if (pop) void'(id_q.pop_front());
    orphan_exp = orphan_exp | orphan_now;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    up_req_vld = '0;
    up_rsp_rdy = '0;
    dn_req_rdy = 1'b0;
    dn_rsp_vld = 1'b0;
    dn_rsp_data = '0;
  endtask

  initial begin
    rst_n       = 1'b0;
    up_req_addr = '0;
    up_req_st   = '0;
    up_req_data = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_cnt", 64'(out_cnt), 64'd0);
    check("rst_err_orphan", 64'(err_orphan), 64'd0);
    check("rst_dn_req_vld", 64'(dn_req_vld), 64'd0);
    check("rst_up_rsp_vld", 64'(up_rsp_vld), 64'd0);
    check("rst_up_req_rdy", 64'(up_req_rdy), 64'd0);
    rst_n = 1'b1;

    // Alternating grants with both requesters held valid.
    set_req(0, 32'h100, 1'b0, 32'h1111);
    set_req(1, 32'h200, 1'b1, 32'h2222);
    up_req_vld = 2'b11;
    dn_req_rdy = 1'b1;
    up_rsp_rdy = 2'b11;
    for (int i = 0; i < 2; i++) begin
      expect_req(0, 32'h100, 1'b0, 32'h1111);
      expect_req(1, 32'h200, 1'b1, 32'h2222);
    end
    tick();
    dn_rsp_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dn_rsp_data = 32'hC000 + 32'(i);
      tick();
    end
    up_req_vld = '0;
    tick();
    dn_rsp_vld = 1'b0;
    tick();
    check("alt_all_granted", 64'(req_q.size()), 64'd0);

    // Move rr_ptr to 1 so the lock, not priority, keeps req0 selected.
    set_req(0, 32'h100, 1'b0, 32'h0);
    up_req_vld = 2'b01;
    expect_req(0, 32'h100, 1'b0, 32'h0);
    tick();
    up_req_vld = '0;
    dn_rsp_vld = 1'b1;
    dn_rsp_data = 32'h5555;
    tick();
    dn_rsp_vld = 1'b0;
    up_req_vld = 2'b01;
    dn_req_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_vld", 64'(dn_req_vld), 64'd1);
      check("stall_addr", 64'(dn_req_addr), 64'h100);
      tick();
    end
    set_req(1, 32'h200, 1'b0, 32'h0);
    up_req_vld = 2'b11;
    #1;
    check("sticky_addr", 64'(dn_req_addr), 64'h100);
    check("sticky_rdy", 64'(up_req_rdy), 64'd0);
    tick();
    dn_req_rdy = 1'b1;
    expect_req(0, 32'h100, 1'b0, 32'h0);
    expect_req(1, 32'h200, 1'b0, 32'h0);
    tick();
    up_req_vld = 2'b10;
    tick();
    up_req_vld = '0;
    dn_rsp_vld = 1'b1;
    tick();
    tick();
    dn_rsp_vld = 1'b0;
    check("sticky_all_granted", 64'(req_q.size()), 64'd0);

    // Outstanding limit, then a same-cycle pop admits the blocked request.
    set_req(0, 32'h300, 1'b0, 32'h0);
    up_req_vld = 2'b01;
    expect_req(0, 32'h300, 1'b0, 32'h0);
    expect_req(0, 32'h300, 1'b0, 32'h0);
    tick();
    tick();
    set_req(1, 32'h400, 1'b0, 32'h0);
    up_req_vld = 2'b10;
    up_rsp_rdy = 2'b01;
    #1;
    check("full_dn_req_vld", 64'(dn_req_vld), 64'd0);
    check("full_up_req_rdy", 64'(up_req_rdy), 64'd0);
    tick();
    dn_rsp_vld = 1'b1;
    dn_rsp_data = 32'h3333;
    expect_req(1, 32'h400, 1'b0, 32'h0);
    #1;
    check("pop_frees_slot", 64'(dn_req_vld), 64'd1);
    tick();
    up_req_vld = '0;
    dn_rsp_vld = 1'b0;
    tick();

    // Response backpressure at head (req0), then drain in order.
    dn_rsp_vld = 1'b1;
    up_rsp_rdy = 2'b10;
    tick();
    tick();
    up_rsp_rdy = 2'b11;
    tick();
    tick();
    dn_rsp_vld = 1'b0;
    tick();

    // In-order routing: req1 then req0; responses AAAA then BBBB.
    set_req(1, 32'h500, 1'b0, 32'h0);
    set_req(0, 32'h600, 1'b0, 32'h0);
    expect_req(1, 32'h500, 1'b0, 32'h0);
    expect_req(0, 32'h600, 1'b0, 32'h0);
    up_req_vld = 2'b10;
    tick();
    up_req_vld = 2'b01;
    tick();
    up_req_vld = '0;
    dn_rsp_vld = 1'b1;
    dn_rsp_data = 32'hAAAA;
    #1;
    check("route_first", 64'(up_rsp_vld), 64'b10);
    tick();
    dn_rsp_data = 32'hBBBB;
    #1;
    check("route_second", 64'(up_rsp_vld), 64'b01);
    check("route_data", 64'(up_rsp_data), 64'hBBBB);
    tick();
    dn_rsp_vld = 1'b0;
    tick();

    // Reset with two outstanding; later responses become orphans.
    set_req(0, 32'h700, 1'b0, 32'h0);
    up_req_vld = 2'b01;
    expect_req(0, 32'h700, 1'b0, 32'h0);
    expect_req(0, 32'h700, 1'b0, 32'h0);
    tick();
    tick();
    up_req_vld = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    id_q.delete();
    rst_n = 1'b1;
    check("rst_mid_out_cnt", 64'(out_cnt), 64'd0);
    dn_rsp_vld = 1'b1;
    dn_rsp_data = 32'hDEAD;
    tick();
    dn_rsp_vld = 1'b0;
    tick();
    tick();
    check("orphan_sticky", 64'(err_orphan), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("orphan_cleared", 64'(err_orphan), 64'd0);
    check("final_queue", 64'(req_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
    $finish;
  end

endmodule
